// File: rtl/sha256_search_ctrl.sv
// Host-side front end for the SHA-256 password search manager: digest load, search handshake, result framing.
// Optional search timeout enabled by defining SHA256_SEARCH_TIMEOUT_EN.
module sha256_search_ctrl #(
  parameter int unsigned n_calculators  = 4,
  parameter int unsigned max_characters = 12,
  parameter int unsigned timeout_cycles = 100000000
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [7:0]                    s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [7:0]                    m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [255:0]                  hash,
  output logic                          start,
  input  logic                          finish,
  input  logic [max_characters*8-1:0]   result_password,
  input  logic [n_calculators-1:0]      winner_calculator,
  output logic                          busy
);

  localparam int unsigned PW_W  = max_characters * 8;
  localparam int unsigned IDX_W = (n_calculators > 1) ? $clog2(n_calculators) : 1;
  localparam int unsigned PTR_W = $clog2(max_characters + 2);
  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_ARM,
    ST_RUN,
    ST_CAPTURE,
    ST_SEND
  } state_e;

  state_e             state_q, state_d;
  logic [255:0]       hash_q, hash_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start_q, start_d;
  logic               tready_q, tready_d;
  logic               busy_q, busy_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic [7:0]         tdata_q, tdata_d;
  logic [PW_W-1:0]    pw_q, pw_d;
  logic [PTR_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic [IDX_W-1:0]   idx_c;
  logic [PW_W-1:0]    pw_c;
  logic [PTR_W-1:0]   len_c;
  logic [PTR_W-1:0]   ptr_nx_c;
  logic [7:0]         byte_c;

`ifdef SHA256_SEARCH_TIMEOUT_EN
  logic [31:0]        tmo_q, tmo_d;
  logic               tmo_hit_c;
  assign tmo_hit_c = (tmo_q == 32'(timeout_cycles - 1));
`else
  logic [31:0]        unused_timeout;
  assign unused_timeout = 32'(timeout_cycles);
`endif

  // Winner index (lowest set bit), reconstructed password and its significant byte length
  always_comb begin
    idx_c = '0;
    for (int i = int'(n_calculators) - 1; i >= 0; i--) begin
      if (winner_calculator[i]) idx_c = IDX_W'(i);
    end
    pw_c  = result_password + PW_W'(idx_c);
    len_c = PTR_W'(1);
    for (int i = 0; i < int'(max_characters); i++) begin
      if (pw_c[8*i +: 8] != 8'h00) len_c = PTR_W'(i + 1);
    end
  end

  // Next frame byte: positions 1..len carry the password, len+1 the winner index
  always_comb begin
    ptr_nx_c = PTR_W'(ptr_q + 1'b1);
    byte_c   = 8'(idx_q);
    if (ptr_nx_c <= len_q) begin
      for (int i = 0; i < int'(max_characters); i++) begin
        if (ptr_nx_c == PTR_W'(i + 1)) byte_c = pw_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= ST_LOAD;
      hash_q   <= '0;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      tready_q <= 1'b1;
      busy_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      pw_q     <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
`ifdef SHA256_SEARCH_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      hash_q   <= hash_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      tready_q <= tready_d;
      busy_q   <= busy_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      pw_q     <= pw_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
`ifdef SHA256_SEARCH_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    hash_d   = hash_q;
    cnt_d    = cnt_q;
    start_d  = start_q;
    tready_d = tready_q;
    busy_d   = busy_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    pw_d     = pw_q;
    len_d    = len_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
`ifdef SHA256_SEARCH_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif

    case (state_q)
      ST_LOAD: begin
        if (s_axis_tvalid && tready_q) begin
          hash_d = {hash_q[247:0], s_axis_tdata};
          if (cnt_q == CNT_W'(31)) begin
            cnt_d    = '0;
            state_d  = ST_ARM;
            start_d  = 1'b1;
            tready_d = 1'b0;
            busy_d   = 1'b1;
`ifdef SHA256_SEARCH_TIMEOUT_EN
            tmo_d    = '0;
`endif
          end else begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
          end
        end
      end

      // A finish still high from the previous search must drop before we listen to it
      ST_ARM: begin
`ifdef SHA256_SEARCH_TIMEOUT_EN
        tmo_d = tmo_q + 32'd1;
`endif
        if (!finish) begin
          state_d = ST_RUN;
`ifdef SHA256_SEARCH_TIMEOUT_EN
        end else if (tmo_hit_c) begin
          state_d  = ST_SEND;
          start_d  = 1'b0;
          tvalid_d = 1'b1;
          tdata_d  = 8'hFF;
          tlast_d  = 1'b1;
`endif
        end
      end

      ST_RUN: begin
`ifdef SHA256_SEARCH_TIMEOUT_EN
        tmo_d = tmo_q + 32'd1;
`endif
        if (finish) begin
          state_d = ST_CAPTURE;
`ifdef SHA256_SEARCH_TIMEOUT_EN
        end else if (tmo_hit_c) begin
          state_d  = ST_SEND;
          start_d  = 1'b0;
          tvalid_d = 1'b1;
          tdata_d  = 8'hFF;
          tlast_d  = 1'b1;
`endif
        end
      end

      ST_CAPTURE: begin
        pw_d     = pw_c;
        len_d    = len_c;
        idx_d    = idx_c;
        ptr_d    = '0;
        start_d  = 1'b0;
        state_d  = ST_SEND;
        tvalid_d = 1'b1;
        tdata_d  = 8'(len_c);
        tlast_d  = 1'b0;
      end

      ST_SEND: begin
        if (m_axis_tready) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
            state_d  = ST_LOAD;
            tready_d = 1'b1;
            busy_d   = 1'b0;
          end else begin
            ptr_d   = ptr_nx_c;
            tdata_d = byte_c;
            tlast_d = (ptr_q == len_q);
          end
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign hash          = hash_q;
  assign start         = start_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_sha256_search_ctrl.sv
// Self-checking bench for sha256_search_ctrl: table vectors, corner-case sequences and randomized searches.
module tb_sha256_search_ctrl;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [7:0]   s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [7:0]   m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [255:0] hash;
  logic         start;
  logic         finish;
  logic [95:0]  result_password;
  logic [3:0]   winner_calculator;
  logic         busy;

  sha256_search_ctrl #(
    .n_calculators (4),
    .max_characters(12),
    .timeout_cycles(100000000)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .hash             (hash),
    .start            (start),
    .finish           (finish),
    .result_password  (result_password),
    .winner_calculator(winner_calculator),
    .busy             (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [95:0]  rp;
    logic [3:0]   win;
    int           n;
    logic [111:0] exp;
  } vec_t;

  vec_t         vec[6];
  int           total = 0;
  int           bad   = 0;
  logic [7:0]   exp_q[$];
  logic [7:0]   got_q[$];
  logic         last_q[$];
  logic [255:0] dig;

  localparam logic [255:0] ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hash"},   hash, '0);
    chk({tag, "_start"},  256'(start), 0);
    chk({tag, "_tvalid"}, 256'(m_axis_tvalid), 0);
    chk({tag, "_tlast"},  256'(m_axis_tlast), 0);
    chk({tag, "_tdata"},  256'(m_axis_tdata), 0);
    chk({tag, "_busy"},   256'(busy), 0);
  endtask

  // Reference: winner index is the lowest set bit, password is an integer sum, length is its byte count
  task automatic model(input logic [95:0] rp, input logic [3:0] win);
    int          idx;
    int          len;
    logic [95:0] pw;
    logic [95:0] sh;
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      if (win[i]) begin
        idx = i;
        break;
      end
    end
    pw  = rp + 96'(idx);
    len = 1;
    while (len < 12 && (pw >> (8 * len)) != 0) len++;
    exp_q.delete();
    exp_q.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      sh = pw >> (8 * i);
      exp_q.push_back(sh[7:0]);
    end
    exp_q.push_back(8'(idx));
  endtask

  task automatic exp_from_vec(input int v);
    logic [111:0] tmp;
    tmp = vec[v].exp;
    exp_q.delete();
    for (int k = 0; k < vec[v].n; k++) exp_q.push_back(tmp[8*k +: 8]);
  endtask

  task automatic send_digest(input logic [255:0] d, input bit gaps);
    for (int i = 0; i < 32; i++) begin
      @(negedge aclk);
      if (gaps && $urandom_range(3) == 0) begin
        s_axis_tvalid = 1'b0;
        @(negedge aclk);
      end
      if (i == 31) chk("start_before_last_beat", 256'(start), 0);
      chk("tready_in_load", 256'(s_axis_tready), 1);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d[8*(31-i) +: 8];
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    chk("hash_loaded", hash, d);
    chk("start_after_load", 256'(start), 1);
    chk("tready_after_load", 256'(s_axis_tready), 0);
    chk("busy_after_load", 256'(busy), 1);
  endtask

  task automatic collect(input int bp_pct);
    bit         done;
    bit         stalled;
    logic [7:0] pd;
    logic       pl;
    done    = 0;
    stalled = 0;
    pd      = '0;
    pl      = 1'b0;
    got_q.delete();
    last_q.delete();
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge aclk);
      if (stalled) begin
        chk("stall_tvalid", 256'(m_axis_tvalid), 1);
        chk("stall_tdata", 256'(m_axis_tdata), 256'(pd));
        chk("stall_tlast", 256'(m_axis_tlast), 256'(pl));
      end
      m_axis_tready = ($urandom_range(99) >= bp_pct);
      stalled = 0;
      if (m_axis_tvalid) begin
        if (m_axis_tready) begin
          got_q.push_back(m_axis_tdata);
          last_q.push_back(m_axis_tlast);
          if (m_axis_tlast) done = 1;
        end else begin
          stalled = 1;
          pd = m_axis_tdata;
          pl = m_axis_tlast;
        end
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: got %0d bytes, no tlast within budget", got_q.size());
    end
    @(negedge aclk);
    m_axis_tready = 1'b0;
    chk("tvalid_after_frame", 256'(m_axis_tvalid), 0);
    chk("busy_after_frame", 256'(busy), 0);
    chk("tready_after_frame", 256'(s_axis_tready), 1);
  endtask

  task automatic check_frame(input string nm);
    chk({nm, "_len"}, 256'(got_q.size()), 256'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", nm, i), 256'(got_q[i]), 256'(exp_q[i]));
      chk($sformatf("%s_last%0d", nm, i), 256'(last_q[i]), 256'(i == exp_q.size() - 1));
    end
  endtask

  task automatic run_search(input logic [95:0] rp, input logic [3:0] win, input int bp, input bit keep);
    @(negedge aclk);
    result_password   = rp;
    winner_calculator = win;
    finish            = 1'b1;
    @(negedge aclk);
    chk("lat_capture_tvalid", 256'(m_axis_tvalid), 0);
    chk("lat_capture_start", 256'(start), 1);
    @(negedge aclk);
    chk("lat_send_tvalid", 256'(m_axis_tvalid), 1);
    chk("lat_send_start", 256'(start), 0);
    collect(bp);
    if (!keep) finish = 1'b0;
    chk("hash_held", hash, dig);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    aresetn           = 1'b0;
    s_axis_tdata      = '0;
    s_axis_tvalid     = 1'b0;
    m_axis_tready     = 1'b0;
    finish            = 1'b0;
    result_password   = '0;
    winner_calculator = '0;

    vec[0] = '{rp: 96'h63625F, win: 4'b0100, n: 5, exp: 112'h0263626103};
    vec[1] = '{rp: 96'h0, win: 4'b0000, n: 3, exp: 112'h000001};
    vec[2] = '{rp: {96{1'b1}}, win: 4'b1000, n: 3, exp: 112'h030201};
    vec[3] = '{rp: 96'hFF, win: 4'b0010, n: 4, exp: 112'h01010002};
    vec[4] = '{rp: 96'h4C4B4A494847464544434241, win: 4'b1010, n: 14,
               exp: 112'h014C4B4A4948474645444342420C};
    vec[5] = '{rp: 96'h00FF00, win: 4'b0000, n: 4, exp: 112'h00FF0002};

    repeat (3) @(negedge aclk);
    chk_reset_vals("reset");
    aresetn = 1'b1;
    @(negedge aclk);
    chk("tready_after_reset", 256'(s_axis_tready), 1);
    chk_reset_vals("post_reset");

    // "abc" digest, then bytes offered outside LOAD must be ignored
    dig = ABC;
    send_digest(dig, 0);
    @(negedge aclk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'hA5;
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    chk("hash_ignores_bytes_outside_load", hash, dig);

    for (int v = 0; v < 6; v++) begin
      if (v > 0) begin
        dig = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        send_digest(dig, 1);
        @(negedge aclk);
      end
      exp_from_vec(v);
      run_search(vec[v].rp, vec[v].win, (v % 2 == 1) ? 50 : 0, 0);
      check_frame($sformatf("vec%0d", v));
    end

    // Same frame under 50% backpressure
    for (int r = 0; r < 3; r++) begin
      dig = ABC;
      send_digest(dig, 0);
      @(negedge aclk);
      exp_from_vec(0);
      run_search(vec[0].rp, vec[0].win, 50, 0);
      check_frame("bp_abc");
    end

    // Stale finish: left high from the previous search while a new digest arrives
    dig = {8{$urandom}};
    send_digest(dig, 0);
    @(negedge aclk);
    exp_from_vec(3);
    run_search(vec[3].rp, vec[3].win, 0, 1);
    check_frame("stale_prev");
    dig = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_digest(dig, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      chk("stale_no_frame", 256'(m_axis_tvalid), 0);
      chk("stale_start_held", 256'(start), 1);
    end
    finish = 1'b0;
    @(negedge aclk);
    chk("stale_still_quiet", 256'(m_axis_tvalid), 0);
    model(96'h636261, 4'b0001);
    run_search(96'h636261, 4'b0001, 30, 0);
    check_frame("stale_next");

    // Reset in the middle of a frame after two bytes
    dig = {8{$urandom}};
    send_digest(dig, 0);
    @(negedge aclk);
    result_password   = vec[4].rp;
    winner_calculator = vec[4].win;
    finish            = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    m_axis_tready = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    aresetn       = 1'b0;
    m_axis_tready = 1'b0;
    finish        = 1'b0;
    @(negedge aclk);
    chk_reset_vals("midsend_reset");
    aresetn = 1'b1;
    @(negedge aclk);
    chk("midsend_tready", 256'(s_axis_tready), 1);
    dig = ABC;
    send_digest(dig, 1);
    @(negedge aclk);
    exp_from_vec(0);
    run_search(vec[0].rp, vec[0].win, 50, 0);
    check_frame("after_reset");

    // Randomized searches against the reference model
    for (int r = 0; r < 20; r++) begin
      logic [95:0] rp;
      logic [95:0] mask;
      logic [3:0]  win;
      int          nb;
      dig  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      nb   = $urandom_range(12);
      mask = (nb == 12) ? {96{1'b1}} : ((96'h1 << (8 * nb)) - 96'h1);
      rp   = {$urandom, $urandom, $urandom} & mask;
      win  = 4'($urandom_range(15));
      send_digest(dig, $urandom_range(1) == 1);
      repeat ($urandom_range(1, 3)) @(negedge aclk);
      model(rp, win);
      run_search(rp, win, ($urandom_range(1) == 1) ? 50 : 0, 0);
      check_frame($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
